efc_fire_sequencer: RTL and testbench
=====================================

EFC_FIRE_SEQUENCER -- requirements
Module: efc_fire_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2: cycles waited after a firing for the FSM state-sync outputs to update (range 1..15).
REQ-002 SHALL have parameter DLK_TIMEOUT, default 15: blocked-request cycles before deadlock is flagged (range 1..255).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  7  firing request per transition t0..t6; level, held by the requester until its fire bit pulses.
REQ-006 SHALL have port mark  input  8  current marking; bit i is place pi as reported by the FSM state-synchronisation outputs.
REQ-007 SHALL have port fire  output  7  one-hot, one-cycle firing pulse driving the FSM transition inputs t0..t6.
REQ-008 SHALL have port busy  output  1  high whenever the block is not in IDLE.
REQ-009 SHALL have port deadlock  output  1  high while requests are pending but none is enabled for DLK_TIMEOUT cycles.

Function
REQ-010 SHALL compute enabled[i] = ((mark & PRESET[i]) == PRESET[i]) and cand = req & enabled, combinationally.
REQ-011 SHALL implement FSM states IDLE, FIRE, SETTLE.
REQ-012 SHALL, in IDLE with cand != 0, select exactly one candidate and enter FIRE next cycle; in IDLE with cand == 0, stay in IDLE.
REQ-013 SHALL assert fire as a registered output for exactly the one FIRE cycle, with only the selected bit set, then enter SETTLE.
REQ-014 SHALL remain in SETTLE for SETTLE_CYCLES cycles and then return to IDLE; req and mark are ignored outside IDLE.
REQ-015 SHALL resolve conflicts (t0/t1 share preset {p0,p1}) by arbitration only; the block never fires two transitions in one cycle.
REQ-016 SHALL maintain an 8-bit saturating block counter: it increments in IDLE when req != 0 and cand == 0, clears when cand != 0 or req == 0, and holds outside IDLE.
REQ-017 SHALL assert deadlock while the block counter >= DLK_TIMEOUT; deadlock does not stall the FSM and clears the cycle after the counter clears.
REQ-018 SHALL keep mark bits with no preset use (none in the default table) functionally ignored.

Reset
REQ-019 SHALL, on reset high at any clock edge, enter IDLE, drive fire = 0, busy = 0, deadlock = 0, clear the block counter, and set the arbitration pointer to 0.
REQ-020 SHALL abort an in-progress FIRE or SETTLE on reset with no further fire pulse; reset dominates all other inputs.

Configuration
REQ-021 SHALL, with macro EFC_FIRE_RR_ARB_EN defined, use round-robin selection: search upward from the pointer with wrap 6->0, then set the pointer to (granted index + 1) mod 7.
REQ-022 SHALL, without EFC_FIRE_RR_ARB_EN, use fixed priority where the lowest candidate index wins and no pointer exists.

Structure
REQ-023 SHALL take from the shared package efc_pkg: NUM_T = 7, NUM_P = 8, the state enum type, and the PRESET table t0:{p0,p1}, t1:{p0,p1}, t2:{p2}, t3:{p3}, t4:{p4}, t5:{p5}, t6:{p6,p7}.
REQ-024 SHALL place arbitration in one sub-module, efc_fire_arb (inputs cand and pointer; output one-hot grant), instantiated once.

Verification
REQ-025 Bench SHALL cover: mark=0x04, req=0x04 -> fire=0x04 one cycle later for one cycle; busy high for 1+SETTLE_CYCLES = 3 cycles.
REQ-026 Bench SHALL cover: mark=0x03, req=0x03, RR macro defined and held -> fire sequence 0x01, 0x02, 0x01, each pulse separated by 3 busy cycles; without the macro -> 0x01 every time.
REQ-027 Bench SHALL cover: mark=0x40, req=0x40 (t6 lacks p7) held for 20 cycles -> fire stays 0 and deadlock rises after 15 IDLE cycles; setting mark=0xC0 -> fire=0x40 and deadlock falls.
REQ-028 Bench SHALL cover: reset asserted during SETTLE -> next cycle busy=0 and fire=0; no pulse occurs until a new IDLE selection.
REQ-029 Bench SHALL cover: req changed during SETTLE -> no effect until IDLE; mark=0xFF, req=0x7F with RR macro defined -> each of t0..t6 fires exactly once in 7 consecutive grants.

Source files
------------

// File: rtl/efc_pkg.sv
// Shared types and constants for the EFC firing sequencer: transition/place counts, FSM states,
// transition preset table and a one-hot to index helper.
package efc_pkg;

  localparam int unsigned NUM_T = 7;
  localparam int unsigned NUM_P = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {
    StIdle,
    StFire,
    StSettle
  } state_e;

  // Input places each transition consumes from; t0 and t1 contend for {p0,p1}.
  localparam logic [NUM_P-1:0] PRESET [NUM_T] = '{
    8'h03, 8'h03, 8'h04, 8'h08, 8'h10, 8'h20, 8'hC0
  };

  function automatic logic [IDX_W-1:0] onehot_idx(input logic [NUM_T-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_T; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/efc_fire_arb.sv
// Picks one firing candidate. Round-robin from the pointer when EFC_FIRE_RR_ARB_EN is defined,
// otherwise fixed priority with the lowest index winning.
module efc_fire_arb
  import efc_pkg::*;
(
  input  logic [NUM_T-1:0] cand,
  input  logic [IDX_W-1:0] pointer,
  output logic [NUM_T-1:0] grant
);

`ifdef EFC_FIRE_RR_ARB_EN
  logic             found;
  logic [IDX_W-1:0] j;

  // Walk upward from the pointer, wrapping past the last transition.
  always_comb begin
    grant = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 0; k < NUM_T; k++) begin
      j = IDX_W'((int'(pointer) + k) % NUM_T);
      if (!found && cand[j]) begin
        grant[j] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`else
  logic unused_pointer;
  assign unused_pointer = ^pointer;
  assign grant          = cand & (~cand + 1'b1);
`endif

endmodule

// File: rtl/efc_fire_sequencer.sv
// Petri-net firing sequencer: fires one enabled, requested transition at a time and waits for the
// marking to settle. Define EFC_FIRE_RR_ARB_EN for round-robin arbitration.
module efc_fire_sequencer
  import efc_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned DLK_TIMEOUT   = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NUM_T-1:0] req,
  input  logic [NUM_P-1:0] mark,
  output logic [NUM_T-1:0] fire,
  output logic             busy,
  output logic             deadlock
);

  localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] DlkThresh  = 8'(DLK_TIMEOUT);

  state_e           state_q, state_d;
  logic [NUM_T-1:0] fire_q, fire_d;
  logic [3:0]       settle_q, settle_d;
  logic [7:0]       blk_q, blk_d;
  logic             busy_q, busy_d;
  logic             deadlock_q, deadlock_d;
  logic [NUM_T-1:0] enabled, cand, grant;
  logic [IDX_W-1:0] ptr;

  always_comb begin
    enabled = '0;
    for (int i = 0; i < NUM_T; i++) begin
      enabled[i] = ((mark & PRESET[i]) == PRESET[i]);
    end
  end

  assign cand = req & enabled;

  efc_fire_arb u_arb (
    .cand    (cand),
    .pointer (ptr),
    .grant   (grant)
  );

`ifdef EFC_FIRE_RR_ARB_EN
  logic [IDX_W-1:0] ptr_q, ptr_d, grant_idx;

  assign grant_idx = onehot_idx(grant);
  assign ptr       = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == StIdle && cand != '0) begin
      ptr_d = (grant_idx == IDX_W'(NUM_T - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  assign ptr = '0;
`endif

  always_comb begin
    state_d  = state_q;
    fire_d   = '0;
    settle_d = settle_q;
    blk_d    = blk_q;
    unique case (state_q)
      StIdle: begin
        if (cand != '0) begin
          state_d = StFire;
          fire_d  = grant;
        end
        // Count only cycles where someone is waiting but nothing can fire.
        if (req != '0 && cand == '0) begin
          if (blk_q != 8'hFF) blk_d = blk_q + 8'd1;
        end else begin
          blk_d = '0;
        end
      end
      StFire: begin
        state_d  = StSettle;
        settle_d = '0;
      end
      StSettle: begin
        if (settle_q == SettleLast) state_d = StIdle;
        else                        settle_d = settle_q + 4'd1;
      end
      default: state_d = StIdle;
    endcase
    busy_d     = (state_d != StIdle);
    deadlock_d = (blk_d >= DlkThresh);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      fire_q     <= '0;
      settle_q   <= '0;
      blk_q      <= '0;
      busy_q     <= 1'b0;
      deadlock_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fire_q     <= fire_d;
      settle_q   <= settle_d;
      blk_q      <= blk_d;
      busy_q     <= busy_d;
      deadlock_q <= deadlock_d;
    end
  end

  assign fire     = fire_q;
  assign busy     = busy_q;
  assign deadlock = deadlock_q;

endmodule

// File: tb/tb_efc_fire_sequencer.sv
// Self-checking bench for efc_fire_sequencer: cycle-level reference model plus directed scenarios
// with literal expectations. Honours EFC_FIRE_RR_ARB_EN like the design.
module tb_efc_fire_sequencer;

  localparam int SETTLE = 2;
  localparam int DLK    = 15;

  logic       clk;
  logic       reset;
  logic [6:0] req;
  logic [7:0] mark;
  logic [6:0] fire;
  logic       busy;
  logic       deadlock;

  int n_pass  = 0;
  int n_total = 0;

  efc_fire_sequencer #(
    .SETTLE_CYCLES (SETTLE),
    .DLK_TIMEOUT   (DLK)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .mark     (mark),
    .fire     (fire),
    .busy     (busy),
    .deadlock (deadlock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: busy countdown, blocked-cycle count and rotating pointer as plain integers.
  logic [7:0] pre_tab [7] = '{8'h03, 8'h03, 8'h04, 8'h08, 8'h10, 8'h20, 8'hC0};
  int         m_busy_left = 0;
  int         m_blocked   = 0;
  int         m_ptr       = 0;
  logic [6:0] m_fire      = '0;
  bit         m_valid     = 1'b0;

  function automatic int pick(input logic [6:0] c, input int p);
`ifdef EFC_FIRE_RR_ARB_EN
    for (int k = 0; k < 7; k++) if (c[(p + k) % 7]) return (p + k) % 7;
`else
    for (int k = 0; k < 7; k++) if (c[k]) return k;
`endif
    return 0;
  endfunction

  always @(posedge clk) begin
    logic [6:0] c;
    int         w;
    if (reset) begin
      m_busy_left = 0;
      m_blocked   = 0;
      m_ptr       = 0;
      m_fire      = '0;
      m_valid     = 1'b1;
    end else if (m_busy_left > 0) begin
      m_busy_left--;
      m_fire = '0;
    end else begin
      c = '0;
      for (int i = 0; i < 7; i++) c[i] = req[i] && ((mark & pre_tab[i]) == pre_tab[i]);
      m_fire = '0;
      if (c != 0) begin
        w           = pick(c, m_ptr);
        m_fire[w]   = 1'b1;
        m_busy_left = 1 + SETTLE;
        m_blocked   = 0;
        m_ptr       = (w + 1) % 7;
      end else if (req != 0) begin
        m_blocked = (m_blocked < 255) ? m_blocked + 1 : 255;
      end else begin
        m_blocked = 0;
      end
    end
    #1;
    if (m_valid) begin
      check("model_fire", fire, m_fire);
      check("model_busy", busy, m_busy_left > 0);
      check("model_deadlock", deadlock, m_blocked >= DLK);
    end
  end

  logic [6:0] pulses[$];
  int         pulse_at[$];

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_collect(input int want, input int budget);
    pulses.delete();
    pulse_at.delete();
    for (int c = 0; c < budget && pulses.size() < want; c++) begin
      @(negedge clk);
      if (fire != 0) begin
        pulses.push_back(fire);
        pulse_at.push_back(c);
      end
    end
    check("pulse_count", pulses.size(), want);
  endtask

  initial begin
    int         bcnt;
    int         fcnt;
    logic [6:0] uni;
    bit         onehot_ok;
    logic [6:0] exp_seq [3];
    reset = 1'b1;
    req   = '0;
    mark  = '0;
    tick(2);
    reset = 1'b0;
    check("reset_fire", fire, 0);
    check("reset_busy", busy, 0);
    check("reset_deadlock", deadlock, 0);
    tick(1);

    // Single enabled request: one pulse, three busy cycles.
    mark = 8'h04;
    req  = 7'h04;
    tick(1);
    check("s1_fire", fire, 7'h04);
    check("s1_busy", busy, 1);
    req  = '0;
    bcnt = 1;
    fcnt = 1;
    for (int k = 0; k < 6; k++) begin
      tick(1);
      if (busy) bcnt++;
      if (fire != 0) fcnt++;
    end
    check("s1_busy_cycles", bcnt, 3);
    check("s1_pulses", fcnt, 1);

    // Conflict t0/t1 held.
    mark = 8'h03;
    req  = 7'h03;
    run_collect(3, 40);
    req = '0;
`ifdef EFC_FIRE_RR_ARB_EN
    exp_seq = '{7'h01, 7'h02, 7'h01};
`else
    exp_seq = '{7'h01, 7'h01, 7'h01};
`endif
    if (pulses.size() == 3) begin
      for (int k = 0; k < 3; k++) check("s2_seq", pulses[k], exp_seq[k]);
      check("s2_gap01", pulse_at[1] - pulse_at[0], 4);
      check("s2_gap12", pulse_at[2] - pulse_at[1], 4);
    end
    tick(4);

    // Blocked t6 (p7 missing): deadlock after 15 blocked cycles, cleared by the firing.
    mark = 8'h40;
    req  = 7'h40;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      check("s3_nofire", fire, 0);
      if (k == 14) check("s3_dlk_k14", deadlock, 0);
      if (k == 15) check("s3_dlk_k15", deadlock, 1);
    end
    check("s3_dlk_k20", deadlock, 1);
    mark = 8'hC0;
    tick(1);
    check("s3_fire", fire, 7'h40);
    check("s3_dlk_clear", deadlock, 0);
    req = '0;
    tick(4);

    // Reset during SETTLE.
    mark = 8'h04;
    req  = 7'h04;
    tick(1);
    check("s4_fire", fire, 7'h04);
    req = '0;
    tick(1);
    reset = 1'b1;
    tick(1);
    check("s4_busy", busy, 0);
    check("s4_fire_rst", fire, 0);
    reset = 1'b0;
    fcnt  = 0;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      if (fire != 0) fcnt++;
    end
    check("s4_no_pulse", fcnt, 0);

    // Request change while settling takes effect only once idle.
    mark = 8'h04;
    req  = 7'h04;
    tick(1);
    check("s5_fire_a", fire, 7'h04);
    req = '0;
    tick(1);
    mark = 8'h0C;
    req  = 7'h08;
    tick(1);
    check("s5_hold1", fire, 0);
    tick(1);
    check("s5_hold2", fire, 0);
    check("s5_idle", busy, 0);
    tick(1);
    check("s5_fire_b", fire, 7'h08);
    req = '0;
    tick(4);

    // All enabled, all requested: seven grants.
    mark = 8'hFF;
    req  = 7'h7F;
    run_collect(7, 60);
    req = '0;
    uni       = '0;
    onehot_ok = 1'b1;
    foreach (pulses[k]) begin
      uni |= pulses[k];
      if (!$onehot(pulses[k])) onehot_ok = 1'b0;
    end
    check("s6_onehot", onehot_ok, 1);
`ifdef EFC_FIRE_RR_ARB_EN
    check("s6_union", uni, 7'h7F);
`else
    check("s6_union", uni, 7'h01);
`endif
    tick(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
